coproc_ctrl: RTL

//  Main sequencer for the image coprocessor: starts a processing pass, gates RAM writes, tracks which

---
 rtl/coproc_ctrl_pkg.sv | 22 ++
 rtl/coproc_ctrl_win_delay.sv | 40 ++++
 rtl/coproc_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/coproc_ctrl_pkg.sv
// Shared types for the image-coprocessor sequencer: FSM states, display sources
// and a helper that sizes the timeout counter.
package coproc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_PROC   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    typedef enum logic {
        SRC_ROM = 1'b0,
        SRC_RAM = 1'b1
    } src_t;

    // The counter only needs to hold values up to n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/coproc_ctrl_win_delay.sv
// Delays the VGA in-window flag by the ROM/RAM read latency so it lines up
// with the returned pixel data. A latency of zero collapses to a wire.
module coproc_ctrl_win_delay #(
    parameter int RD_LAT = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_win,
    output logic o_win_d
);

    generate
        if (RD_LAT == 0) begin : g_wire
            assign o_win_d = i_win;
        end else begin : g_pipe
            logic [RD_LAT-1:0] r_shift;
            logic [RD_LAT-1:0] w_stage_in;
            genvar gi;

            for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    assign w_stage_in[gi] = i_win;
                end else begin : g_rest
                    assign w_stage_in[gi] = r_shift[gi-1];
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= w_stage_in;
                end
            end

            assign o_win_d = r_shift[RD_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/coproc_ctrl.sv
// Main sequencer for the image coprocessor: runs a processing pass, gates RAM
// writes, tracks result validity and picks ROM or RAM pixels for the VGA path.
module coproc_ctrl
    import coproc_ctrl_pkg::*;
#(
    parameter int              PIX_W        = 8,
    parameter int              ADDR_W       = 17,
    parameter int              N_ALG        = 4,
    parameter int              ALG_W        = 2,
    parameter int              RD_LAT       = 1,
    parameter int              TIMEOUT_CYC  = 1048576,
    parameter logic [PIX_W-1:0] BORDER_COLOR = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_alg_next,
    input  logic              i_src_force_rom,
    input  logic              i_frame_start,
    input  logic              i_proc_done,
    input  logic              i_proc_wvalid,
    input  logic [ADDR_W-1:0] i_proc_waddr,
    input  logic              i_in_window,
    input  logic [PIX_W-1:0]  i_rom_pix,
    input  logic [PIX_W-1:0]  i_ram_pix,
    output logic              o_proc_start,
    output logic              o_ram_wren,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic [ALG_W-1:0]  o_sel_alg,
    output logic [ALG_W-1:0]  o_active_alg,
    output logic [PIX_W-1:0]  o_color_out,
    output logic              o_busy,
    output logic              o_frame_valid,
    output logic              o_timeout_err
);

    localparam int TO_W = cnt_width(TIMEOUT_CYC);

    state_t             r_state;
    state_t             w_state_next;
    src_t               r_src;
    src_t               r_pending;
    src_t               w_pending_next;
    logic [TO_W-1:0]    r_to_cnt;
    logic [ALG_W-1:0]   r_sel_alg;
    logic [ALG_W-1:0]   r_active_alg;
    logic               r_proc_start;
    logic               r_ram_wren;
    logic [ADDR_W-1:0]  r_ram_waddr;
    logic [PIX_W-1:0]   r_color;
    logic               r_frame_valid;
    logic               r_timeout_err;
    logic               w_to_hit;
    logic               w_proc_start_next;
    logic               w_wren_next;
    logic               w_busy;
    logic               w_win_d;

    assign w_to_hit = (r_state == ST_PROC) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PROC_DONE is checked ahead of the timeout so a late finish still commits.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_run) w_state_next = ST_ARM;
            ST_ARM:    w_state_next = ST_PROC;
            ST_PROC: begin
                if (i_proc_done)   w_state_next = ST_COMMIT;
                else if (w_to_hit) w_state_next = ST_IDLE;
            end
            ST_COMMIT: if (i_frame_start) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_proc_start_next = (r_state == ST_ARM);
        w_wren_next       = i_proc_wvalid && (r_state == ST_PROC);
        w_busy            = (r_state != ST_IDLE);
        w_pending_next    = r_pending;
        if (r_state == ST_IDLE && i_run) begin
            w_pending_next = SRC_ROM;
        end else if (r_state == ST_COMMIT && i_frame_start) begin
            w_pending_next = SRC_RAM;
        end
    end

    coproc_ctrl_win_delay #(
        .RD_LAT (RD_LAT)
    ) u_win_delay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_win   (i_in_window),
        .o_win_d (w_win_d)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_proc_start  <= 1'b0;
            r_ram_wren    <= 1'b0;
            r_ram_waddr   <= '0;
            r_sel_alg     <= '0;
            r_active_alg  <= '0;
            r_to_cnt      <= '0;
            r_frame_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            r_pending     <= SRC_ROM;
            r_src         <= SRC_ROM;
            r_color       <= BORDER_COLOR;
        end else begin
            r_proc_start <= w_proc_start_next;
            r_ram_wren   <= w_wren_next;
            r_ram_waddr  <= i_proc_waddr;
            r_pending    <= w_pending_next;

            if (i_alg_next) begin
                r_sel_alg <= (r_sel_alg == ALG_W'(N_ALG - 1)) ? '0 : r_sel_alg + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_run) begin
                        r_active_alg  <= r_sel_alg;
                        r_timeout_err <= 1'b0;
                        r_frame_valid <= 1'b0;
                        r_to_cnt      <= '0;
                    end
                end
                ST_PROC: begin
                    if (!i_proc_done) begin
                        if (w_to_hit) r_timeout_err <= 1'b1;
                        else          r_to_cnt      <= r_to_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (i_frame_start) r_frame_valid <= 1'b1;
                end
                default: ;
            endcase

            // A commit at this boundary is shown from this frame onward.
            if (i_frame_start) r_src <= w_pending_next;

            if (!w_win_d) begin
                r_color <= BORDER_COLOR;
            end else if (r_src == SRC_RAM && r_frame_valid && !i_src_force_rom) begin
                r_color <= i_ram_pix;
            end else begin
                r_color <= i_rom_pix;
            end
        end
    end

    assign o_proc_start  = r_proc_start;
    assign o_ram_wren    = r_ram_wren;
    assign o_ram_waddr   = r_ram_waddr;
    assign o_sel_alg     = r_sel_alg;
    assign o_active_alg  = r_active_alg;
    assign o_color_out   = r_color;
    assign o_busy        = w_busy;
    assign o_frame_valid = r_frame_valid;
    assign o_timeout_err = r_timeout_err;

endmodule
